reaction_seq_fsm: RTL

//  Parametrised reaction-timer sequencer for the DE1 reaction-time lab.

---
 rtl/reaction_seq_if.sv | 31 +++
 rtl/reaction_seq_fsm.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/reaction_seq_if.sv
// Reaction-timer sequencer bus.
// Groups the strobes coming from the prescalers, pushbutton and delay block,
// together with the LED, LFSR-control and result signals going back out.
//   master : environment side (drives tick/ms_tick/trigger/time_out)
//   slave  : sequencer side   (drives en_lfsr/start_delay/ledr/react_time/
//                              result_valid/false_start)
interface reaction_seq_if #(
    parameter int N_LIGHTS = 10,
    parameter int RT_W     = 14
);
    logic                tick;          // 1-cycle step strobe
    logic                ms_tick;       // 1-cycle 1 ms strobe
    logic                trigger;       // active-low pushbutton, synchronised
    logic                time_out;      // random delay expired (1-cycle pulse)
    logic                en_lfsr;       // 1 = LFSR free-runs
    logic                start_delay;   // 1-cycle pulse: start random delay
    logic [N_LIGHTS-1:0] ledr;          // LED pattern
    logic [RT_W-1:0]     react_time;    // last reaction time in ms
    logic                result_valid;  // 1-cycle pulse on react_time update
    logic                false_start;   // last run aborted by an early press

    modport master (
        output tick, ms_tick, trigger, time_out,
        input  en_lfsr, start_delay, ledr, react_time, result_valid, false_start
    );

    modport slave (
        input  tick, ms_tick, trigger, time_out,
        output en_lfsr, start_delay, ledr, react_time, result_valid, false_start
    );
endinterface

// File: rtl/reaction_seq_fsm.sv
// Reaction-timer sequencer for the DE1 reaction-time lab.
// Lights N_LIGHTS LEDs one step per tick, hands off to the random-delay block,
// then counts ms until the user presses the button. A press before the timing
// phase is a false start. All outputs are registered.
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    reaction_seq_if.slave: tick, ms_tick, trigger, time_out in;
//          en_lfsr, start_delay, ledr, react_time, result_valid,
//          false_start out
module reaction_seq_fsm #(
    parameter int N_LIGHTS  = 10,
    parameter int RT_W      = 14,
    parameter int FILL_MODE = 0
) (
    input  logic          clk,
    input  logic          rst_n,
    reaction_seq_if.slave bus
);

    localparam int STEP_W = $clog2(N_LIGHTS + 1);
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(N_LIGHTS - 1);
    localparam logic [RT_W-1:0]   RT_MAX    = '1;
    localparam logic [RT_W-1:0]   RT_LAST   = RT_MAX - 1'b1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LIGHT,
        S_HOLD,
        S_RUN,
        S_DONE,
        S_FAULT
    } state_t;

    state_t state_q, next_state;

    logic                trig_q;
    logic                press;
    logic [STEP_W-1:0]   step_q, step_d, step_inc;
    logic [RT_W-1:0]     rt_cnt_q, rt_cnt_d;
    logic [N_LIGHTS-1:0] ledr_q, ledr_d;
    logic [RT_W-1:0]     react_time_q, react_time_d;
    logic                en_lfsr_q, en_lfsr_d;
    logic                start_delay_q, start_delay_d;
    logic                result_valid_q, result_valid_d;
    logic                false_start_q, false_start_d;

    // Falling edge of the active-low button; a held button yields one press.
    assign press = trig_q & ~bus.trigger;

    // LED pattern for an intermediate step s (1..N_LIGHTS-1).
    function automatic logic [N_LIGHTS-1:0] light_pattern(input logic [STEP_W-1:0] s);
        logic [N_LIGHTS-1:0] p;
        for (int i = 0; i < N_LIGHTS; i++) begin
            if (FILL_MODE == 0) p[i] = (i < int'(s));
            else                p[i] = (i == int'(s) - 1);
        end
        return p;
    endfunction

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: clocked state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= next_state;
    end

    // ------------------------------------------------------------------
    // Next-state logic. A press always wins over a coincident strobe.
    // ------------------------------------------------------------------
    // NOTE: every combinational output is given a default first so no path
    // leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        next_state = state_q;
        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (press) next_state = S_LIGHT;
            end
            S_LIGHT: begin
                if (press)                             next_state = S_FAULT;
                else if (bus.tick && step_q == LAST_STEP) next_state = S_HOLD;
            end
            S_HOLD: begin
                if (press)             next_state = S_FAULT;
                else if (bus.time_out) next_state = S_RUN;
            end
            S_RUN: begin
                if (press)                               next_state = S_DONE;
                else if (bus.ms_tick && rt_cnt_q == RT_LAST) next_state = S_DONE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output / datapath logic: next values of the registered outputs.
    // ------------------------------------------------------------------
    always_comb begin
        step_d         = step_q;
        step_inc       = step_q + 1'b1;
        rt_cnt_d       = rt_cnt_q;
        ledr_d         = ledr_q;
        react_time_d   = react_time_q;
        false_start_d  = false_start_q;
        start_delay_d  = 1'b0;
        result_valid_d = 1'b0;
        // LFSR runs whenever the sequencer is waiting for a new start.
        en_lfsr_d      = (next_state == S_IDLE) || (next_state == S_DONE) ||
                         (next_state == S_FAULT);

        case (state_q)
            S_IDLE, S_DONE, S_FAULT: begin
                if (press) begin
                    step_d        = '0;
                    ledr_d        = '0;
                    false_start_d = 1'b0;
                end
            end
            S_LIGHT: begin
                if (press) begin
                    ledr_d        = '0;
                    false_start_d = 1'b1;
                end else if (bus.tick) begin
                    step_d = step_inc;
                    if (step_q == LAST_STEP) begin
                        ledr_d        = '1;
                        start_delay_d = 1'b1;
                    end else begin
                        ledr_d = light_pattern(step_inc);
                    end
                end
            end
            S_HOLD: begin
                if (press) begin
                    ledr_d        = '0;
                    false_start_d = 1'b1;
                end else if (bus.time_out) begin
                    ledr_d   = '0;
                    rt_cnt_d = '0;
                end
            end
            S_RUN: begin
                if (press) begin
                    // Coincident ms_tick is dropped: latch the count as is.
                    react_time_d   = rt_cnt_q;
                    result_valid_d = 1'b1;
                end else if (bus.ms_tick) begin
                    rt_cnt_d = rt_cnt_q + 1'b1;
                    if (rt_cnt_q == RT_LAST) begin
                        react_time_d   = RT_MAX;
                        result_valid_d = 1'b1;
                    end
                end
            end
            default: ;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath and output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_q         <= 1'b1;
            step_q         <= '0;
            rt_cnt_q       <= '0;
            ledr_q         <= '0;
            react_time_q   <= '0;
            en_lfsr_q      <= 1'b1;
            start_delay_q  <= 1'b0;
            result_valid_q <= 1'b0;
            false_start_q  <= 1'b0;
        end else begin
            trig_q         <= bus.trigger;
            step_q         <= step_d;
            rt_cnt_q       <= rt_cnt_d;
            ledr_q         <= ledr_d;
            react_time_q   <= react_time_d;
            en_lfsr_q      <= en_lfsr_d;
            start_delay_q  <= start_delay_d;
            result_valid_q <= result_valid_d;
            false_start_q  <= false_start_d;
        end
    end

    assign bus.ledr         = ledr_q;
    assign bus.react_time   = react_time_q;
    assign bus.en_lfsr      = en_lfsr_q;
    assign bus.start_delay  = start_delay_q;
    assign bus.result_valid = result_valid_q;
    assign bus.false_start  = false_start_q;

endmodule
